// File: rtl/wb_arbiter2.sv
// Two-master / one-slave Wishbone classic arbiter: round-robin grant, locked for the whole cyc.
// Optional slave watchdog is compiled in with `define WB_ARB_TIMEOUT_EN.
module wb_arbiter2 #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                  m0_cyc_i,
  input  logic                  m0_strobe_i,
  input  logic                  m0_we_i,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_ack_o,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                  m1_cyc_i,
  input  logic                  m1_strobe_i,
  input  logic                  m1_we_i,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_ack_o,
  output logic [DATA_WIDTH-1:0] s_data_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic                  s_cyc_o,
  output logic                  s_strobe_o,
  output logic                  s_we_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_ack_i,
  output logic [1:0]            grant,
  output logic                  timeout_flag
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e r_state, w_state_next;
  logic   r_last_owner, w_last_owner_next;
  logic   w_own0, w_own1;
  logic   w_timeout;

  // Gating with reset drops the slave cycle in the same cycle reset is sampled.
  assign w_own0 = reset && (r_state == StOwn0);
  assign w_own1 = reset && (r_state == StOwn1);
  assign grant  = {r_state == StOwn1, r_state == StOwn0};

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DATA_WIDTH-1:0] TimeoutData = DATA_WIDTH'(32'hDEADBEEF);

  logic [CntWidth-1:0] r_cnt, w_cnt_inc;
  logic                w_stall;
  logic                r_timeout_flag;

  assign w_stall   = ((w_own0 && m0_strobe_i) || (w_own1 && m1_strobe_i)) && !s_ack_i;
  // w_cnt_inc counts stalled cycles including the current one.
  assign w_cnt_inc = r_cnt + CntWidth'(1);
  assign w_timeout = w_stall && (w_cnt_inc == CntWidth'(TIMEOUT_CYCLES));

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt          <= '0;
      r_timeout_flag <= 1'b0;
    end else begin
      if (w_timeout) begin
        r_timeout_flag <= 1'b1;
      end
      if (w_timeout || s_ack_i || w_state_next == StIdle) begin
        r_cnt <= '0;
      end else if (w_stall) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  assign timeout_flag = r_timeout_flag;
`else
  assign w_timeout    = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_last_owner <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_last_owner <= w_last_owner_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_last_owner_next = r_last_owner;
    case (r_state)
      StIdle: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_state_next = r_last_owner ? StOwn0 : StOwn1;
        end else if (m0_cyc_i) begin
          w_state_next = StOwn0;
        end else if (m1_cyc_i) begin
          w_state_next = StOwn1;
        end
        if (w_state_next == StOwn0) begin
          w_last_owner_next = 1'b0;
        end else if (w_state_next == StOwn1) begin
          w_last_owner_next = 1'b1;
        end
      end
      StOwn0: begin
        if (!m0_cyc_i || w_timeout) begin
          w_state_next = StIdle;
        end
      end
      StOwn1: begin
        if (!m1_cyc_i || w_timeout) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    s_addr_o   = '0;
    s_data_o   = '0;
    s_we_o     = 1'b0;
    s_cyc_o    = 1'b0;
    s_strobe_o = 1'b0;
    m0_ack_o   = 1'b0;
    m1_ack_o   = 1'b0;
    m0_data_o  = s_data_i;
    m1_data_o  = s_data_i;
    if (w_own0) begin
      s_addr_o   = m0_addr_i;
      s_data_o   = m0_data_i;
      s_we_o     = m0_we_i;
      s_cyc_o    = m0_cyc_i;
      s_strobe_o = m0_strobe_i;
      m0_ack_o   = s_ack_i;
    end else if (w_own1) begin
      s_addr_o   = m1_addr_i;
      s_data_o   = m1_data_i;
      s_we_o     = m1_we_i;
      s_cyc_o    = m1_cyc_i;
      s_strobe_o = m1_strobe_i;
      m1_ack_o   = s_ack_i;
    end
`ifdef WB_ARB_TIMEOUT_EN
    // Watchdog fires: abort the slave cycle and hand the owner an error-data ack.
    if (w_timeout) begin
      s_cyc_o    = 1'b0;
      s_strobe_o = 1'b0;
      if (w_own0) begin
        m0_ack_o  = 1'b1;
        m0_data_o = TimeoutData;
      end else begin
        m1_ack_o  = 1'b1;
        m1_data_o = TimeoutData;
      end
    end
`endif
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: expectations are queued with the stimulus and compared
// against DUT outputs shortly after inputs settle, away from the clock edge.
module tb_wb_arbiter2;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] m0_data_i, m0_addr_i, m1_data_i, m1_addr_i, s_data_i;
  logic        m0_cyc_i, m0_strobe_i, m0_we_i, m1_cyc_i, m1_strobe_i, m1_we_i, s_ack_i;
  logic [31:0] m0_data_o, m1_data_o, s_data_o, s_addr_o;
  logic        m0_ack_o, m1_ack_o, s_cyc_o, s_strobe_o, s_we_o, timeout_flag;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;

  localparam int SelGrant = 0, SelCyc = 1, SelAddr = 2, SelAck0 = 3, SelAck1 = 4;
  localparam int SelData0 = 5, SelData1 = 6, SelTmo = 7, SelStb = 8, SelWe = 9, SelSdat = 10;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  wb_arbiter2 #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .m0_data_i   (m0_data_i),
    .m0_addr_i   (m0_addr_i),
    .m0_cyc_i    (m0_cyc_i),
    .m0_strobe_i (m0_strobe_i),
    .m0_we_i     (m0_we_i),
    .m0_data_o   (m0_data_o),
    .m0_ack_o    (m0_ack_o),
    .m1_data_i   (m1_data_i),
    .m1_addr_i   (m1_addr_i),
    .m1_cyc_i    (m1_cyc_i),
    .m1_strobe_i (m1_strobe_i),
    .m1_we_i     (m1_we_i),
    .m1_data_o   (m1_data_o),
    .m1_ack_o    (m1_ack_o),
    .s_data_o    (s_data_o),
    .s_addr_o    (s_addr_o),
    .s_cyc_o     (s_cyc_o),
    .s_strobe_o  (s_strobe_o),
    .s_we_o      (s_we_o),
    .s_data_i    (s_data_i),
    .s_ack_i     (s_ack_i),
    .grant       (grant),
    .timeout_flag(timeout_flag)
  );

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SelGrant: return {30'd0, grant};
      SelCyc:   return {31'd0, s_cyc_o};
      SelAddr:  return s_addr_o;
      SelAck0:  return {31'd0, m0_ack_o};
      SelAck1:  return {31'd0, m1_ack_o};
      SelData0: return m0_data_o;
      SelData1: return m1_data_o;
      SelTmo:   return {31'd0, timeout_flag};
      SelStb:   return {31'd0, s_strobe_o};
      SelWe:    return {31'd0, s_we_o};
      SelSdat:  return s_data_o;
      default:  return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic expect_v(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  // Let combinational outputs settle, then drain the scoreboard.
  task automatic settle();
    exp_t        e;
    logic [31:0] obs;
    #2;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.val)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    {m0_data_i, m0_addr_i, m1_data_i, m1_addr_i, s_data_i} = '0;
    {m0_cyc_i, m0_strobe_i, m0_we_i, m1_cyc_i, m1_strobe_i, m1_we_i, s_ack_i} = '0;
    tick();
    tick();
    expect_v("rst_grant", SelGrant, 0);
    expect_v("rst_cyc", SelCyc, 0);
    expect_v("rst_stb", SelStb, 0);
    expect_v("rst_ack0", SelAck0, 0);
    expect_v("rst_ack1", SelAck1, 0);
    expect_v("rst_tmo", SelTmo, 0);
    settle();

    // Master 0 single write
    reset = 1'b1;
    m0_cyc_i = 1; m0_strobe_i = 1; m0_we_i = 1; m0_addr_i = 32'h10; m0_data_i = 32'h5;
    expect_v("w_grant_pre", SelGrant, 0);
    expect_v("w_cyc_pre", SelCyc, 0);
    settle();
    tick();
    expect_v("w_grant", SelGrant, 1);
    expect_v("w_addr", SelAddr, 32'h10);
    expect_v("w_sdata", SelSdat, 32'h5);
    expect_v("w_we", SelWe, 1);
    expect_v("w_cyc", SelCyc, 1);
    settle();
    s_ack_i = 1;
    expect_v("w_ack0", SelAck0, 1);
    expect_v("w_ack1", SelAck1, 0);
    settle();
    tick();
    s_ack_i = 0; m0_cyc_i = 0; m0_strobe_i = 0; m0_we_i = 0;
    expect_v("w_cyc_drop", SelCyc, 0);
    settle();
    tick();
    expect_v("w_idle", SelGrant, 0);
    expect_v("w_idle_addr", SelAddr, 0);
    settle();

    // Simultaneous request after reset: master 0 first, then master 1
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m0_cyc_i = 1; m0_strobe_i = 1; m0_addr_i = 32'h20;
    m1_cyc_i = 1; m1_strobe_i = 1; m1_addr_i = 32'h30;
    tick();
    expect_v("rr_first", SelGrant, 2'b01);
    expect_v("rr_addr0", SelAddr, 32'h20);
    settle();
    m0_cyc_i = 0; m0_strobe_i = 0;
    tick();
    expect_v("rr_gap", SelGrant, 2'b00);
    settle();
    tick();
    expect_v("rr_second", SelGrant, 2'b10);
    expect_v("rr_addr1", SelAddr, 32'h30);
    settle();

    // Master 1 read
    s_data_i = 32'hCAFEF00D; s_ack_i = 1;
    expect_v("rd_ack1", SelAck1, 1);
    expect_v("rd_data1", SelData1, 32'hCAFEF00D);
    expect_v("rd_ack0", SelAck0, 0);
    settle();
    tick();
    s_ack_i = 0; m1_cyc_i = 0; m1_strobe_i = 0;
    tick();
    expect_v("rd_idle", SelGrant, 0);
    settle();

    // Lock: master 1 waits through three reads by master 0
    m0_cyc_i = 1; m0_strobe_i = 1;
    tick();
    expect_v("lk_grant0", SelGrant, 2'b01);
    settle();
    m1_cyc_i = 1; m1_strobe_i = 1;
    for (int i = 0; i < 3; i++) begin
      s_ack_i = 1; s_data_i = 32'h100 + i;
      expect_v("lk_ack0", SelAck0, 1);
      expect_v("lk_ack1", SelAck1, 0);
      expect_v("lk_data0", SelData0, 32'h100 + i);
      settle();
      tick();
      s_ack_i = 0;
      expect_v("lk_hold", SelGrant, 2'b01);
      settle();
      tick();
    end
    m0_cyc_i = 0; m0_strobe_i = 0;
    tick();
    expect_v("lk_gap", SelGrant, 2'b00);
    settle();
    tick();
    expect_v("lk_grant1", SelGrant, 2'b10);
    settle();

    // Reset mid-cycle in OWN1
    reset = 1'b0;
    expect_v("mr_cyc_now", SelCyc, 0);
    settle();
    tick();
    expect_v("mr_grant", SelGrant, 0);
    expect_v("mr_cyc", SelCyc, 0);
    settle();
    reset = 1'b1; m1_cyc_i = 0; m1_strobe_i = 0; s_ack_i = 1;
    expect_v("mr_stray1", SelAck1, 0);
    expect_v("mr_stray0", SelAck0, 0);
    settle();
    s_ack_i = 0;
    tick();

    // Master drops cyc with strobe outstanding; late ack is dropped
    m0_cyc_i = 1; m0_strobe_i = 1;
    tick();
    expect_v("la_grant", SelGrant, 2'b01);
    settle();
    m0_cyc_i = 0;
    tick();
    s_ack_i = 1;
    expect_v("la_idle", SelGrant, 0);
    expect_v("la_ack0", SelAck0, 0);
    expect_v("la_stb", SelStb, 0);
    settle();
    s_ack_i = 0; m0_strobe_i = 0;
    tick();

    // Hung slave
    m0_cyc_i = 1; m0_strobe_i = 1;
    tick();
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      expect_v("to_wait_ack0", SelAck0, 0);
      expect_v("to_wait_grant", SelGrant, 2'b01);
      settle();
      tick();
    end
    expect_v("to_ack0", SelAck0, 1);
    expect_v("to_data0", SelData0, 32'hDEADBEEF);
    expect_v("to_cyc", SelCyc, 0);
    expect_v("to_stb", SelStb, 0);
    expect_v("to_ack1", SelAck1, 0);
    settle();
    m0_cyc_i = 0; m0_strobe_i = 0;
    tick();
    expect_v("to_idle", SelGrant, 0);
    expect_v("to_flag", SelTmo, 1);
    settle();
    tick();
    expect_v("to_sticky", SelTmo, 1);
    settle();
`else
    for (int i = 0; i < 20; i++) tick();
    expect_v("hang_grant", SelGrant, 2'b01);
    expect_v("hang_ack0", SelAck0, 0);
    expect_v("hang_cyc", SelCyc, 1);
    expect_v("hang_flag", SelTmo, 0);
    settle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
